// File: rtl/io_bridge.sv
// io_bridge: bridge between the CPU data port and up to six memory-mapped
// peripherals, with a small interrupt controller and bus-error capture.
//
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   CPU_Addr/WD/WE/RE CPU byte address, write data, write and read strobes
//   CPU_RD            combinational read data (device, control reg, or all ones)
//   DEV_Addr          word index inside a device window (CPU_Addr[3:2])
//   DEV_WD            write data forwarded to every device
//   DEV_WE            one-hot per-device write strobe
//   DEV_RD            packed device read data, device k at [32k+31:32k]
//   DEV_Int           raw device interrupt requests
//   HWInt             registered masked pending interrupts, bits >= NDEV zero
//
// Control window (word index CPU_Addr[3:2]):
//   0 IMASK  R/W      1 IPEND  RO level / W1C edge
//   2 ERRADDR RO      3 ERRCNT saturating, any write clears
module io_bridge #(
  parameter int unsigned NDEV      = 2,
  parameter logic [31:0] BASE      = 32'h00007F00,
  parameter int unsigned NWORDS    = 3,
  parameter logic [31:0] CTRL_BASE = 32'h00007F80,
  parameter logic [5:0]  EDGE_MASK = 6'b000000
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [31:0]          CPU_Addr,
  input  logic [31:0]          CPU_WD,
  input  logic                 CPU_WE,
  input  logic                 CPU_RE,
  output logic [31:0]          CPU_RD,
  output logic [1:0]           DEV_Addr,
  output logic [31:0]          DEV_WD,
  output logic [NDEV-1:0]      DEV_WE,
  input  logic [32*NDEV-1:0]   DEV_RD,
  input  logic [NDEV-1:0]      DEV_Int,
  output logic [5:0]           HWInt
);

  logic [31:0]     addr_w;
  logic [1:0]      word;
  logic [NDEV-1:0] hit;
  logic            hit_c;
  logic            bus_err;
  logic            wr_ctrl;

  logic [NDEV-1:0] imask;
  logic [NDEV-1:0] pend;
  logic [NDEV-1:0] pend_next;
  logic [NDEV-1:0] int_q;
  logic [31:0]     erraddr;
  logic [7:0]      errcnt;
  logic [31:0]     ctrl_rd;
  logic [5:0]      hw_next;
  logic [NDEV-1:0] edge_ch;
  logic [NDEV-1:0] w1c;
  logic [NDEV-1:0] rise;

  assign addr_w   = {CPU_Addr[31:2], 2'b00};
  assign word     = CPU_Addr[3:2];
  assign DEV_Addr = word;
  assign DEV_WD   = CPU_WD;
  assign edge_ch  = EDGE_MASK[NDEV-1:0];

  // Address decode: each device window covers only its implemented words,
  // so addresses in the hole words fall through to the bus-error path.
  always_comb begin
    hit = '0;
    for (int unsigned k = 0; k < NDEV; k++) begin
      hit[k] = (addr_w >= BASE + 32'(16 * k)) &&
               (addr_w <  BASE + 32'(16 * k + 4 * NWORDS));
    end
  end

  assign hit_c   = (addr_w >= CTRL_BASE) && (addr_w < CTRL_BASE + 32'd16);
  assign bus_err = (CPU_WE | CPU_RE) & ~(|hit) & ~hit_c;
  assign wr_ctrl = CPU_WE & hit_c;
  assign DEV_WE  = hit & {NDEV{CPU_WE}};

  always_comb begin
    ctrl_rd = '0;
    case (word)
      2'd0:    ctrl_rd[NDEV-1:0] = imask;
      2'd1:    ctrl_rd[NDEV-1:0] = pend;
      2'd2:    ctrl_rd           = erraddr;
      default: ctrl_rd[7:0]      = errcnt;
    endcase
  end

  always_comb begin
    CPU_RD = '1;
    if (hit_c) CPU_RD = ctrl_rd;
    for (int unsigned k = 0; k < NDEV; k++) begin
      if (hit[k]) CPU_RD = DEV_RD[32*k +: 32];
    end
  end

  // Edge channels: a fresh rising edge in the same cycle as a W1C keeps
  // the bit set. Level channels simply track the raw request.
  assign w1c  = (wr_ctrl && word == 2'd1) ? CPU_WD[NDEV-1:0] : '0;
  assign rise = DEV_Int & ~int_q;

  always_comb begin
    pend_next = '0;
    for (int unsigned k = 0; k < NDEV; k++) begin
      if (edge_ch[k]) pend_next[k] = rise[k] | (pend[k] & ~w1c[k]);
      else            pend_next[k] = DEV_Int[k];
    end
  end

  always_comb begin
    hw_next = '0;
    hw_next[NDEV-1:0] = pend & imask;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      imask   <= '1;
      pend    <= '0;
      int_q   <= '0;
      HWInt   <= '0;
      erraddr <= '0;
      errcnt  <= '0;
    end else begin
      int_q <= DEV_Int;
      pend  <= pend_next;
      HWInt <= hw_next;
      if (wr_ctrl && word == 2'd0) imask <= CPU_WD[NDEV-1:0];
      if (bus_err) erraddr <= CPU_Addr;
      // A control-window write is a hit, so clear and count never coincide.
      if (wr_ctrl && word == 2'd3)          errcnt <= '0;
      else if (bus_err && errcnt != 8'hFF)  errcnt <= errcnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_io_bridge.sv
module tb_io_bridge;

  localparam logic [31:0] P_BASE = 32'h00007F00;
  localparam logic [31:0] P_CTRL = 32'h00007F80;
  localparam int          P_NW   = 3;
  localparam logic [5:0]  P_EM   = 6'b000010;

  logic        CLK, RST;
  logic [31:0] CPU_Addr, CPU_WD, CPU_RD, DEV_WD;
  logic        CPU_WE, CPU_RE;
  logic [1:0]  DEV_Addr, DEV_WE, DEV_Int;
  logic [63:0] DEV_RD;
  logic [5:0]  HWInt;

  logic [31:0] mem [0:1][0:3];

  int total = 0;
  int bad   = 0;

  // Reference state
  logic [1:0]  m_imask, m_pend, m_intq;
  logic [5:0]  m_hw;
  logic [31:0] m_erraddr;
  int          m_errcnt;

  io_bridge #(
    .NDEV(2), .BASE(P_BASE), .NWORDS(P_NW), .CTRL_BASE(P_CTRL), .EDGE_MASK(P_EM)
  ) dut (
    .CLK(CLK), .RST(RST), .CPU_Addr(CPU_Addr), .CPU_WD(CPU_WD),
    .CPU_WE(CPU_WE), .CPU_RE(CPU_RE), .CPU_RD(CPU_RD), .DEV_Addr(DEV_Addr),
    .DEV_WD(DEV_WD), .DEV_WE(DEV_WE), .DEV_RD(DEV_RD), .DEV_Int(DEV_Int),
    .HWInt(HWInt)
  );

  assign DEV_RD = {mem[1][DEV_Addr], mem[0][DEV_Addr]};

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  // Returns device index, 8 for the control window, -1 for no hit.
  function automatic int decode(input logic [31:0] a);
    logic [31:0] aw, b;
    aw = a & ~32'h3;
    for (int k = 0; k < 2; k++) begin
      b = P_BASE + 32'(16 * k);
      if (aw >= b && (aw - b) < 32'(4 * P_NW)) return k;
    end
    if (aw >= P_CTRL && (aw - P_CTRL) < 32'd16) return 8;
    return -1;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    int d;
    int w;
    d = decode(a);
    w = int'((a >> 2) % 4);
    if (d == 8) begin
      if (w == 0) return {30'd0, m_imask};
      if (w == 1) return {30'd0, m_pend};
      if (w == 2) return m_erraddr;
      return 32'(m_errcnt);
    end
    if (d >= 0) return mem[d][w];
    return 32'hFFFFFFFF;
  endfunction

  task automatic model_edge();
    int d;
    int w;
    logic [1:0] np;
    logic [5:0] nh;
    if (RST) begin
      m_imask = 2'b11; m_pend = 0; m_intq = 0; m_hw = 0;
      m_erraddr = 0; m_errcnt = 0;
      return;
    end
    d  = decode(CPU_Addr);
    w  = int'((CPU_Addr >> 2) % 4);
    nh = {4'd0, m_pend & m_imask};
    for (int k = 0; k < 2; k++) begin
      if (P_EM[k]) begin
        if (DEV_Int[k] && !m_intq[k])                          np[k] = 1'b1;
        else if (CPU_WE && d == 8 && w == 1 && CPU_WD[k])      np[k] = 1'b0;
        else                                                   np[k] = m_pend[k];
      end else begin
        np[k] = DEV_Int[k];
      end
    end
    if (CPU_WE && d == 8 && w == 0) m_imask = CPU_WD[1:0];
    if ((CPU_WE || CPU_RE) && d < 0) begin
      m_erraddr = CPU_Addr;
      if (m_errcnt < 255) m_errcnt++;
    end
    if (CPU_WE && d == 8 && w == 3) m_errcnt = 0;
    m_pend = np;
    m_hw   = nh;
    m_intq = DEV_Int;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic set_bus(input logic [31:0] a, input logic [31:0] wd,
                         input logic we, input logic re);
    CPU_Addr = a; CPU_WD = wd; CPU_WE = we; CPU_RE = re;
    #1;
  endtask

  task automatic test_reset();
    RST = 1; DEV_Int = 0;
    m_imask = 2'b11; m_pend = 0; m_intq = 0; m_hw = 0; m_erraddr = 0; m_errcnt = 0;
    set_bus(P_CTRL, 0, 0, 0);
    total++; if (HWInt !== 6'd0) begin bad++; $display("FAIL reset_hwint: got %h want 00", HWInt); end
    total++; if (CPU_RD !== 32'h3) begin bad++; $display("FAIL reset_imask: got %h want 3", CPU_RD); end
    set_bus(P_CTRL + 8, 0, 0, 0);
    total++; if (CPU_RD !== 32'h0) begin bad++; $display("FAIL reset_erraddr: got %h want 0", CPU_RD); end
    set_bus(P_CTRL + 12, 0, 0, 0);
    total++; if (CPU_RD !== 32'h0) begin bad++; $display("FAIL reset_errcnt: got %h want 0", CPU_RD); end
    tick(); tick();
    RST = 0;
  endtask

  task automatic test_device();
    set_bus(32'h00007F14, 32'h0000000B, 1, 0);
    total++; if (DEV_WE !== 2'b10) begin bad++; $display("FAIL dev_we: got %b want 10", DEV_WE); end
    total++; if (DEV_Addr !== 2'd1) begin bad++; $display("FAIL dev_addr: got %0d want 1", DEV_Addr); end
    total++; if (DEV_WD !== 32'hB) begin bad++; $display("FAIL dev_wd: got %h want b", DEV_WD); end
    tick();
    set_bus(32'h00007F18, 0, 0, 1);
    total++; if (CPU_RD !== mem[1][2]) begin bad++; $display("FAIL dev_read: got %h want %h", CPU_RD, mem[1][2]); end
    set_bus(32'h00007F02, 0, 0, 1);
    total++; if (CPU_RD !== mem[0][0]) begin bad++; $display("FAIL dev_read_lowbits: got %h want %h", CPU_RD, mem[0][0]); end
    tick();
    set_bus(P_CTRL + 12, 0, 0, 0);
    total++; if (CPU_RD !== 32'h0) begin bad++; $display("FAIL hit_no_err: got %h want 0", CPU_RD); end
  endtask

  task automatic test_errors();
    set_bus(32'h00007F0C, 32'h12345678, 1, 1);
    total++; if (CPU_RD !== 32'hFFFFFFFF) begin bad++; $display("FAIL hole_rd: got %h want ffffffff", CPU_RD); end
    total++; if (DEV_WE !== 2'b00) begin bad++; $display("FAIL hole_we: got %b want 00", DEV_WE); end
    tick();
    set_bus(P_CTRL + 8, 0, 0, 0);
    total++; if (CPU_RD !== 32'h00007F0C) begin bad++; $display("FAIL erraddr: got %h want 00007f0c", CPU_RD); end
    set_bus(P_CTRL + 12, 0, 0, 0);
    total++; if (CPU_RD !== 32'd1) begin bad++; $display("FAIL errcnt_one: got %h want 1", CPU_RD); end
    for (int i = 0; i < 300; i++) begin
      set_bus(32'h00001000 + 32'(4 * i), 0, 0, 1);
      tick();
    end
    set_bus(P_CTRL + 12, 0, 0, 0);
    total++; if (CPU_RD !== 32'd255) begin bad++; $display("FAIL errcnt_sat: got %h want ff", CPU_RD); end
    set_bus(P_CTRL + 8, 0, 0, 0);
    total++; if (CPU_RD !== 32'h00001000 + 32'(4 * 299)) begin bad++; $display("FAIL erraddr_last: got %h want %h", CPU_RD, 32'h00001000 + 32'(4 * 299)); end
    set_bus(P_CTRL + 12, 32'hDEAD, 1, 0);
    tick();
    set_bus(P_CTRL + 12, 0, 0, 0);
    total++; if (CPU_RD !== 32'd0) begin bad++; $display("FAIL errcnt_clear: got %h want 0", CPU_RD); end
  endtask

  task automatic test_level();
    set_bus(0, 0, 0, 0);
    DEV_Int[0] = 1;
    tick();
    total++; if (HWInt[0] !== 1'b0) begin bad++; $display("FAIL level_lat1: got %b want 0", HWInt[0]); end
    tick();
    total++; if (HWInt !== 6'b000001) begin bad++; $display("FAIL level_on: got %b want 000001", HWInt); end
    DEV_Int[0] = 0;
    tick();
    total++; if (HWInt[0] !== 1'b1) begin bad++; $display("FAIL level_hold: got %b want 1", HWInt[0]); end
    tick();
    total++; if (HWInt !== 6'b000000) begin bad++; $display("FAIL level_off: got %b want 000000", HWInt); end
  endtask

  task automatic test_edge();
    DEV_Int[1] = 1;
    tick();
    DEV_Int[1] = 0;
    tick();
    total++; if (HWInt !== 6'b000010) begin bad++; $display("FAIL edge_on: got %b want 000010", HWInt); end
    tick(); tick();
    total++; if (HWInt !== 6'b000010) begin bad++; $display("FAIL edge_held: got %b want 000010", HWInt); end
    set_bus(P_CTRL + 4, 32'h2, 1, 0);
    tick();
    set_bus(0, 0, 0, 0);
    tick();
    total++; if (HWInt !== 6'b000000) begin bad++; $display("FAIL edge_w1c: got %b want 000000", HWInt); end
    set_bus(P_CTRL + 4, 32'h2, 1, 0);
    DEV_Int[1] = 1;
    tick();
    set_bus(0, 0, 0, 0);
    DEV_Int[1] = 0;
    tick();
    total++; if (HWInt[1] !== 1'b1) begin bad++; $display("FAIL edge_set_wins: got %b want 1", HWInt[1]); end
    set_bus(P_CTRL + 4, 32'h2, 1, 0);
    tick();
    set_bus(0, 0, 0, 0);
    tick();
  endtask

  task automatic test_mask();
    DEV_Int[0] = 1;
    tick(); tick();
    set_bus(P_CTRL, 32'h0, 1, 0);
    tick();
    set_bus(P_CTRL + 4, 0, 0, 0);
    tick();
    total++; if (HWInt !== 6'b000000) begin bad++; $display("FAIL mask_off: got %b want 000000", HWInt); end
    total++; if (CPU_RD !== 32'h1) begin bad++; $display("FAIL mask_ipend: got %h want 1", CPU_RD); end
    set_bus(P_CTRL, 32'h3, 1, 0);
    tick();
    set_bus(0, 0, 0, 0);
    tick();
    total++; if (HWInt !== 6'b000001) begin bad++; $display("FAIL mask_restore: got %b want 000001", HWInt); end
  endtask

  task automatic test_async_reset();
    DEV_Int[0] = 1;
    tick();
    set_bus(32'h00007F0C, 0, 0, 1);
    tick();
    total++; if (HWInt !== 6'b000001) begin bad++; $display("FAIL pre_reset_pending: got %b want 000001", HWInt); end
    DEV_Int = 0;
    set_bus(P_CTRL + 4, 0, 0, 0);
    #1 RST = 1;
    #1;
    total++; if (HWInt !== 6'd0) begin bad++; $display("FAIL areset_hwint: got %b want 0", HWInt); end
    total++; if (CPU_RD !== 32'd0) begin bad++; $display("FAIL areset_ipend: got %h want 0", CPU_RD); end
    set_bus(P_CTRL + 12, 0, 0, 0);
    total++; if (CPU_RD !== 32'd0) begin bad++; $display("FAIL areset_errcnt: got %h want 0", CPU_RD); end
    set_bus(P_CTRL, 0, 0, 0);
    total++; if (CPU_RD !== 32'h3) begin bad++; $display("FAIL areset_imask: got %h want 3", CPU_RD); end
    tick();
    RST = 0;
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] e;
    logic [1:0]  ewe;
    int d;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0, 1:    a = P_BASE + 32'(16 * $urandom_range(0, 1)) + 32'($urandom_range(0, 15));
        2:       a = P_CTRL + 32'($urandom_range(0, 15));
        3:       a = $urandom;
        default: a = P_BASE + 32'($urandom_range(0, 255));
      endcase
      DEV_Int = 2'($urandom_range(0, 3));
      set_bus(a, $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
      d   = decode(a);
      e   = exp_rd(a);
      ewe = (CPU_WE && d >= 0 && d < 2) ? 2'(1 << d) : 2'b00;
      total++; if (CPU_RD !== e) begin bad++; $display("FAIL rnd_rd[%0d] addr=%h: got %h want %h", i, a, CPU_RD, e); end
      total++; if (DEV_WE !== ewe) begin bad++; $display("FAIL rnd_we[%0d] addr=%h: got %b want %b", i, a, DEV_WE, ewe); end
      tick();
      total++; if (HWInt !== m_hw) begin bad++; $display("FAIL rnd_hwint[%0d]: got %b want %b", i, HWInt, m_hw); end
    end
    set_bus(0, 0, 0, 0);
    DEV_Int = 0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 4; w++)
        mem[k][w] = $urandom;
    CPU_Addr = 0; CPU_WD = 0; CPU_WE = 0; CPU_RE = 0; DEV_Int = 0; RST = 1;
    test_reset();
    test_device();
    test_errors();
    test_level();
    test_edge();
    test_mask();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
